// File: rtl/pixel_stream_xform.sv
// Streams one frame from SRC_BASE through a per-pixel operation into DST_BASE, one pixel per clock.
// Define PIXEL_XFORM_MIRROR_EN to enable mode 5 (pass-through with horizontal mirroring).

module pixel_stream_xform #(
    parameter int          IMG_W    = 320,
    parameter int          IMG_H    = 320,
    parameter logic [31:0] SRC_BASE = 32'd0,
    parameter logic [31:0] DST_BASE = 32'd131072,
    parameter int          RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic        pause,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_ONE   = XW'(1);
    localparam logic [YW-1:0] Y_ONE   = YW'(1);
    localparam logic [31:0]   IMG_W_U = 32'(IMG_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [2:0]        mode_r;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic [XW-1:0]     rd_x_r;
    logic [YW-1:0]     rd_y_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic              rd_en_r;
    logic [31:0]       rd_addr_r;
    logic              wr_en_r;
    logic [31:0]       wr_addr_r;
    logic [31:0]       wr_data_r;
    logic [RD_LAT-1:0] pv_r;
    logic [XW-1:0]     px_r [RD_LAT];
    logic [YW-1:0]     py_r [RD_LAT];
    logic              issue_s;
    logic              accept_s;
    logic              reject_s;
    logic              last_pix_s;
    logic              pending_s;
    logic [31:0]       src_addr_s;
    logic [31:0]       dst_addr_s;
    logic [XW-1:0]     wr_x_s;

    function automatic logic mode_ok(input logic [2:0] m);
        logic ok;
        case (m)
            3'd0, 3'd1, 3'd2, 3'd3: ok = 1'b1;
`ifdef PIXEL_XFORM_MIRROR_EN
            3'd5:                   ok = 1'b1;
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Grayscale averages through a 10-bit sum so 3*255 cannot overflow.
    function automatic logic [31:0] xform(input logic [31:0] px, input logic [2:0] m);
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [9:0]  sum;
        logic [7:0]  gray;
        logic [31:0] res;
        r    = px[23:16];
        g    = px[15:8];
        b    = px[7:0];
        sum  = {2'b00, r} + {2'b00, g} + {2'b00, b};
        gray = 8'(sum / 10'd3);
        case (m)
            3'd0:    res = {8'h00, r, g, b};
            3'd1:    res = {8'h00, gray, gray, gray};
            3'd2:    res = {8'h00, r, 8'h00, b};
            3'd3:    res = {8'h00, ~r, ~g, ~b};
            default: res = {8'h00, r, g, b};
        endcase
        return res;
    endfunction

    assign last_pix_s = (x_r == X_LAST) && (y_r == Y_LAST);
    assign pending_s  = rd_en_r | (|pv_r);
    assign src_addr_s = SRC_BASE + 32'(y_r) * IMG_W_U + 32'(x_r);
    assign dst_addr_s = DST_BASE + 32'(py_r[RD_LAT-1]) * IMG_W_U + 32'(wr_x_s);

    // Destination column, mirrored when the optional mode is active.
    always_comb begin
        wr_x_s = px_r[RD_LAT-1];
`ifdef PIXEL_XFORM_MIRROR_EN
        if (mode_r == 3'd5) begin
            wr_x_s = X_LAST - px_r[RD_LAT-1];
        end else begin
            wr_x_s = px_r[RD_LAT-1];
        end
`endif
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (mode_ok(mode)) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else begin
                        reject_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!pause) begin
                    issue_s = 1'b1;
                    if (last_pix_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!pending_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State, status flags, raster counters and read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mode_r    <= 3'd0;
            x_r       <= '0;
            y_r       <= '0;
            rd_x_r    <= '0;
            rd_y_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            rd_en_r   <= 1'b0;
            rd_addr_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r  <= (state_nxt_s == ST_DONE);
            rd_en_r <= issue_s;
            if (accept_s) begin
                mode_r  <= mode;
                error_r <= 1'b0;
                x_r     <= '0;
                y_r     <= '0;
            end else if (reject_s) begin
                mode_r  <= mode;
                error_r <= 1'b1;
            end else if (issue_s) begin
                rd_addr_r <= src_addr_s;
                rd_x_r    <= x_r;
                rd_y_r    <= y_r;
                if (x_r == X_LAST) begin
                    x_r <= '0;
                    y_r <= last_pix_s ? '0 : (y_r + Y_ONE);
                end else begin
                    x_r <= x_r + X_ONE;
                end
            end else begin
                x_r <= x_r;
            end
        end
    end

    // Coordinates ride alongside the read valid until rd_data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                px_r[i] <= '0;
                py_r[i] <= '0;
            end
        end else begin
            pv_r[0] <= rd_en_r;
            px_r[0] <= rd_x_r;
            py_r[0] <= rd_y_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_r[i] <= pv_r[i-1];
                px_r[i] <= px_r[i-1];
                py_r[i] <= py_r[i-1];
            end
        end
    end

    // Registered transform result and write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 32'd0;
            wr_data_r <= 32'd0;
        end else begin
            wr_en_r <= pv_r[RD_LAT-1];
            if (pv_r[RD_LAT-1]) begin
                wr_addr_r <= dst_addr_s;
                wr_data_r <= xform(rd_data, mode_r);
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign error   = error_r;
    assign rd_en   = rd_en_r;
    assign rd_addr = rd_addr_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

endmodule

// File: tb/tb_pixel_stream_xform.sv
// Scoreboard bench for pixel_stream_xform on a 4x3 frame, read latency 1, destination base 100.
// Covers pass/grayscale/remove-green/invert, pause, invalid mode, mid-frame reset and mode 5.

module tb_pixel_stream_xform;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mode;
    logic        pause;
    logic        busy;
    logic        done;
    logic        error;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] src_mem [16];
    logic [31:0] wr_log  [16];
    logic [31:0] first_wr_data;
    int n_pass, n_chk;
    int cyc, rd_idx, wr_cnt, gap, last_wr_cyc, rd_total, done_total;
    int cur_mode, exp_gap;
    logic busy_q;

    pixel_stream_xform #(
        .IMG_W(4), .IMG_H(3), .SRC_BASE(32'd0), .DST_BASE(32'd100), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .pause(pause),
        .busy(busy), .done(done), .error(error),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= src_mem[rd_addr[3:0]];
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic [31:0] p, input int m);
        int r, g, b, gv;
        logic [7:0] g8;
        r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
        gv = (r + g + b) / 3;
        g8 = 8'(gv);
        case (m)
            1:       return {8'h00, g8, g8, g8};
            2:       return {8'h00, p[23:16], 8'h00, p[7:0]};
            3:       return {8'h00, 8'(255 - r), 8'(255 - g), 8'(255 - b)};
            default: return {8'h00, p[23:0]};
        endcase
    endfunction

    function automatic logic [31:0] exp_dst(input int idx, input int m);
        int x, y;
        x = idx % 4;
        y = idx / 4;
        if (m == 5) x = 3 - x;
        return 32'(100 + y * 4 + x);
    endfunction

    // Monitor: push expectations on reads, pop and compare on writes, check frame end.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb.delete();
            busy_q = 1'b0;
        end else begin
            if (busy && !busy_q) begin
                rd_idx = 0; wr_cnt = 0; gap = 0;
            end
            busy_q = busy;
            if (rd_en) begin
                rd_total++;
                chk_val("rd_addr", rd_addr, 32'(rd_idx));
                mon_e.addr = exp_dst(rd_idx, cur_mode);
                mon_e.data = model(src_mem[rd_idx % 16], cur_mode);
                mon_e.cyc  = cyc;
                sb.push_back(mon_e);
                rd_idx++;
            end else if (busy && rd_idx > 0 && rd_idx < 12) begin
                gap++;
            end
            if (wr_en) begin
                chk_val("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk_val("wr_addr", wr_addr, mon_e.addr);
                    chk_val("wr_data", wr_data, mon_e.data);
                    chk_val("wr_lat", 32'(cyc - mon_e.cyc), 32'd2);
                end
                if (wr_cnt < 16) wr_log[wr_cnt] = wr_addr;
                if (wr_cnt == 0) first_wr_data = wr_data;
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (done) begin
                done_total++;
                chk_val("done_after_wr", 32'(cyc - last_wr_cyc), 32'd1);
                chk_val("done_busy", 32'(busy), 32'd0);
                chk_val("wr_count", 32'(wr_cnt), 32'd12);
                chk_val("rd_gap", 32'(gap), 32'(exp_gap));
                chk_val("sb_empty", 32'(sb.size()), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame(input int m);
        cur_mode = m;
        start = 1'b1;
        mode  = 3'(m);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_reads(input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < 200 && seen < n; k++) begin
            tick();
            if (rd_en) seen++;
        end
        chk_val("reads_seen", 32'(seen), 32'(n));
    endtask

    task automatic wait_done();
        int d0;
        d0 = done_total;
        for (int k = 0; k < 300 && done_total == d0; k++) tick();
        chk_val("frame_done", 32'(done_total > d0), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_val({tag, "_flags"}, {26'd0, busy, done, error, rd_en, wr_en, 1'b0}, 32'd0);
        chk_val({tag, "_rd_addr"}, rd_addr, 32'd0);
        chk_val({tag, "_wr_addr"}, wr_addr, 32'd0);
        chk_val({tag, "_wr_data"}, wr_data, 32'd0);
    endtask

    initial begin
        int r0, d0;
        n_pass = 0; n_chk = 0; cyc = 0; rd_idx = 0; wr_cnt = 0; gap = 0;
        last_wr_cyc = 0; rd_total = 0; done_total = 0; cur_mode = 0; exp_gap = 0;
        busy_q = 1'b0; first_wr_data = 32'd0; rd_data = 32'd0;
        start = 1'b0; mode = 3'd0; pause = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            src_mem[i] = 32'(i * 32'h010203);
            wr_log[i]  = 32'd0;
        end
        #3 rst_n = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        start_frame(0);
        chk_val("busy_running", 32'(busy), 32'd1);
        wait_done();
        chk_val("pass_px0", first_wr_data, 32'h00000000);
        chk_val("pass_last_addr", wr_log[11], 32'd111);

        src_mem[0] = 32'h00FF0102;
        start_frame(1);
        wait_done();
        chk_val("gray_px0", first_wr_data, 32'h00565656);

        src_mem[0]  = 32'h00123456;
        src_mem[11] = 32'hAB123456;
        start_frame(2);
        wait_done();
        chk_val("rmg_px0", first_wr_data, 32'h00120056);
        start_frame(3);
        wait_done();
        chk_val("inv_px0", first_wr_data, 32'h00EDCBA9);

        exp_gap = 3;
        start_frame(0);
        wait_reads(5);
        pause = 1'b1;
        repeat (3) tick();
        pause = 1'b0;
        wait_done();
        exp_gap = 0;

        r0 = rd_total; d0 = done_total;
        start_frame(6);
        repeat (10) tick();
        chk_val("bad_mode_err", 32'(error), 32'd1);
        chk_val("bad_mode_busy", 32'(busy), 32'd0);
        chk_val("bad_mode_no_rd", 32'(rd_total - r0), 32'd0);
        chk_val("bad_mode_no_done", 32'(done_total - d0), 32'd0);

        start_frame(0);
        chk_val("err_cleared", 32'(error), 32'd0);
        wait_reads(3);
        start = 1'b1;
        mode  = 3'd3;
        tick();
        start = 1'b0;
        wait_done();

        d0 = done_total;
        start_frame(0);
        wait_reads(7);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk_val("reset_no_done", 32'(done_total - d0), 32'd0);
        start_frame(0);
        wait_done();

`ifdef PIXEL_XFORM_MIRROR_EN
        start_frame(5);
        wait_done();
        chk_val("mirror_src1", wr_log[1], 32'd102);
        chk_val("mirror_src4", wr_log[4], 32'd107);
`else
        r0 = rd_total;
        start_frame(5);
        repeat (10) tick();
        chk_val("mode5_err", 32'(error), 32'd1);
        chk_val("mode5_no_rd", 32'(rd_total - r0), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
